// File: rtl/lb_window_ctrl.sv
// Line-buffer sequencer: accepts a raster pixel stream, drives the line-buffer write enable
// and reports every pixel position that completes a WIN x WIN window.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame
// FILL  | accepting rows 0..WIN-2, no window possible yet
// RUN   | windows are being produced
// DONE  | frame complete, input refused until the last window drains
module lb_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int WIN   = 3,
  parameter int CW    = 7
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          lb_wen,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_col,
  output logic [CW-1:0] out_row,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN - 1);
  localparam logic [CW-1:0] ROW_PRE  = CW'(WIN - 2);

  state_t        state, state_nxt;
  logic [CW-1:0] col, row;
  logic          accept, col_wrap, last_pix, win_hit;

  // RESET gates in_ready so no write can slip out while reset is held
  always_comb begin
    in_ready = !RESET && (state != DONE) && !flush && !(out_valid && !out_ready);
    accept   = in_valid && in_ready;
    lb_wen   = accept;
    col_wrap = (col == COL_LAST);
    last_pix = col_wrap && (row == ROW_LAST);
    win_hit  = accept && (row >= WIN_LAST) && (col >= WIN_LAST);
    busy     = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = FILL;
      FILL: if (accept && col_wrap && row == ROW_PRE) state_nxt = RUN;
      RUN:  if (accept && last_pix) state_nxt = DONE;
      DONE: if (!out_valid || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      col <= '0;
      row <= '0;
    end else if (flush) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_pix) begin
        col <= '0;
        row <= '0;
      end else if (col_wrap) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // A load wins over a drain in the same cycle, which gives one window per clock
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_valid  <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= !flush && accept && last_pix;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (win_hit) begin
        out_valid <= 1'b1;
        out_col   <= col;
        out_row   <= row;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lb_window_ctrl.sv
// Bench for lb_window_ctrl: directed phases plus random valid/ready traffic, each cycle
// compared against a pixel-index reference model of the frame.
module tb_lb_window_ctrl;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int WN   = 3;
  localparam int CW   = 7;
  localparam int NWIN = (W - WN + 1) * (H - WN + 1);

  logic          CLK = 1'b0;
  logic          RESET, in_valid, flush, out_ready;
  logic          in_ready, lb_wen, out_valid, busy, frame_done;
  logic [CW-1:0] out_col, out_row;

  lb_window_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(WN), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .lb_wen(lb_wen), .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_row(out_row), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame position as a flat pixel index
  int p, m_oc, m_or, win_cnt, last_pos, frames;
  bit m_ov, m_done, m_fd, m_busy;

  task automatic model_reset();
    p = 0; m_ov = 0; m_oc = 0; m_or = 0; m_done = 0; m_fd = 0; m_busy = 0;
    win_cnt = 0; last_pos = -1;
  endtask

  task automatic step(input bit iv, input bit ordy, input bit fl);
    bit rdy, acc, ov_pre, done_pre;
    int c, r, pos;
    in_valid = iv; out_ready = ordy; flush = fl;
    #1;
    rdy = !m_done && !fl && !(m_ov && !ordy);
    acc = iv && rdy;
    chk("in_ready", in_ready, rdy);
    chk("lb_wen", lb_wen, acc);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      chk("out_col", out_col, m_oc);
      chk("out_row", out_row, m_or);
    end
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_fd);
    if (out_valid && ordy) begin
      pos = int'(out_row) * W + int'(out_col);
      chk("raster_order", pos > last_pos, 1);
      last_pos = pos;
      win_cnt++;
    end
    @(posedge CLK);
    ov_pre = m_ov; done_pre = m_done;
    m_fd = 0;
    if (fl) begin
      p = 0; m_ov = 0; m_done = 0; m_busy = 0; win_cnt = 0; last_pos = -1;
    end else begin
      c = p % W;
      r = p / W;
      if (acc && r >= WN - 1 && c >= WN - 1) begin
        m_ov = 1; m_oc = c; m_or = r;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (acc) begin
        m_busy = 1;
        if (p == W * H - 1) begin
          p = 0; m_done = 1; m_fd = 1;
        end else begin
          p++;
        end
      end
      if (done_pre && (!ov_pre || ordy)) begin
        m_done = 0; m_busy = 0;
        chk("windows_per_frame", win_cnt, NWIN);
        win_cnt = 0; last_pos = -1;
        frames++;
      end
    end
    #1;
  endtask

  task automatic run_to_frame(input int target, input bit iv, input int budget);
    for (int i = 0; i < budget && frames < target; i++) step(iv, 1'b1, 1'b0);
    chk("frame_timeout", frames >= target, 1);
  endtask

  initial begin
    int hold, f0;
    bit flushed;
    RESET = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    frames = 0;
    model_reset();
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_row", out_row, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // two back-to-back frames at full rate
    run_to_frame(2, 1'b1, 200);

    // stall the first window of the next frame
    hold = 0;
    for (int i = 0; i < 200 && frames < 3; i++) begin
      bit ordy;
      ordy = !(m_ov && m_oc == 2 && m_or == 2 && hold < 6);
      if (!ordy) hold++;
      step(1'b1, ordy, 1'b0);
    end
    chk("stall_frame_timeout", frames >= 3, 1);
    chk("stall_cycles", hold, 6);

    // flush on the 13th pixel, then a clean frame
    flushed = 0;
    for (int i = 0; i < 40 && !flushed; i++) begin
      if (p == 12) begin
        step(1'b1, 1'b1, 1'b1);
        flushed = 1;
      end else begin
        step(1'b1, 1'b1, 1'b0);
      end
    end
    chk("flush_reached", flushed, 1);
    run_to_frame(4, 1'b1, 200);

    // asynchronous reset in the middle of RUN
    for (int i = 0; i < 40 && p != 20; i++) step(1'b1, 1'b1, 1'b0);
    chk("pre_reset_busy", busy, 1);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #2 RESET = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_out_col", out_col, 0);
    chk("async_out_row", out_row, 0);
    in_valid = 1'b1;
    #1;
    chk("async_lb_wen", lb_wen, 0);
    chk("async_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    run_to_frame(5, 1'b1, 200);

    // random traffic
    f0 = frames;
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    chk("random_frames_seen", frames - f0 >= 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
